// File: rtl/bus_host.sv
`default_nettype none
// ============================================================================
//  Module   : bus_host
//  Purpose  : Half-duplex byte-bus host. Sends a buffered command of up to
//             CMD_DEPTH bytes to a peripheral, then turns the bus around and
//             collects 16-bit words (low byte first) until the peripheral
//             signals frame completion or a cycle timeout expires.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n           clock (rising edge), synchronous active-low reset
//    cmd_we/waddr/wdata   command buffer write port (usable in any state)
//    cmd_len              bytes to send, sampled on start (clamped to depth)
//    start                one-cycle transaction request, ignored while busy
//    busy, done, timeout  status: not-IDLE level, completion pulses
//    word_valid/data/addr one-cycle strobe per received word with its index
//    word_count           words received in the last finished transaction
//    dir_o                1 = host owns bus and holds peripheral in reset
//    req_o/req_oe         host strobe and its drive enable
//    data_o/data_oe       host data byte and its drive enable
//    req_i, data_i, fin_i peripheral data-ready, data byte, frame complete
// ============================================================================
module bus_host #(
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT   = 2**20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_we,
  input  logic [$clog2(CMD_DEPTH)-1:0] cmd_waddr,
  input  logic [7:0]                   cmd_wdata,
  input  logic [$clog2(CMD_DEPTH):0]   cmd_len,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         word_valid,
  output logic [15:0]                  word_data,
  output logic [16:0]                  word_addr,
  output logic [16:0]                  word_count,
  output logic                         dir_o,
  output logic                         req_o,
  output logic                         req_oe,
  input  logic                         req_i,
  output logic [7:0]                   data_o,
  output logic                         data_oe,
  input  logic [7:0]                   data_i,
  input  logic                         fin_i
);

  localparam int          AW        = $clog2(CMD_DEPTH);
  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam int          TMO_LAST_I = TIMEOUT - 1;
  localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];
  localparam logic [AW:0]   DEPTH_L  = CMD_DEPTH[AW:0];
  localparam logic [16:0]   CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    WRITE    = 3'd2,
    POST     = 3'd3,
    WAIT_REQ = 3'd4,
    READ     = 3'd5,
    DONE     = 3'd6,
    TOUT     = 3'd7
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [CMD_DEPTH];
  logic [AW:0]     len;
  logic [AW:0]     widx;
  logic [TW-1:0]   tcnt;
  logic            phase;      // 0: expecting low byte, 1: expecting high byte
  logic [7:0]      low_byte;
  logic [16:0]     count;
  logic            tmo_hit;
  logic            capture;

  // Command buffer: never reset, so contents survive an aborted transaction.
  always_ff @(posedge clk) begin
    if (cmd_we) mem[cmd_waddr] <= cmd_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore outputs. fin_i is tested before the timeout and
  // before any capture so it always wins a same-cycle conflict.
  always_comb begin
    state_nxt = state;
    tmo_hit   = (tcnt == TMO_LAST);
    capture   = 1'b0;
    busy      = (state != IDLE);
    dir_o     = (state == IDLE) || (state == PRE) || (state == WRITE) || (state == POST);
    req_o     = (state == WRITE);
    data_o    = (state == WRITE) ? mem[widx[AW-1:0]] : 8'h00;
    done      = (state == DONE);
    timeout   = (state == TOUT);
    req_oe    = dir_o;
    data_oe   = dir_o;
    case (state)
      IDLE:     if (start) state_nxt = PRE;
      PRE:      state_nxt = (len != '0) ? WRITE : POST;
      WRITE:    if (widx == len - 1'b1) state_nxt = POST;
      POST:     state_nxt = WAIT_REQ;
      WAIT_REQ: begin
        if (fin_i)        state_nxt = DONE;
        else if (tmo_hit) state_nxt = TOUT;
        else if (req_i)   state_nxt = READ;
      end
      READ: begin
        if (fin_i)        state_nxt = DONE;
        else if (tmo_hit) state_nxt = TOUT;
        else if (req_i)   capture   = 1'b1;
      end
      DONE:     state_nxt = IDLE;
      TOUT:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len        <= '0;
      widx       <= '0;
      tcnt       <= '0;
      phase      <= 1'b0;
      low_byte   <= 8'h00;
      count      <= '0;
      word_valid <= 1'b0;
      word_data  <= 16'h0000;
      word_addr  <= '0;
      word_count <= '0;
    end else begin
      word_valid <= 1'b0;

      if (state == IDLE && start)
        len <= (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;

      if (state == PRE)        widx <= '0;
      else if (state == WRITE) widx <= widx + 1'b1;

      // Counters are cleared on the way into WAIT_REQ so that an immediate
      // fin_i or timeout there already reports a zero word count.
      if (state == POST) begin
        tcnt  <= '0;
        phase <= 1'b0;
        count <= '0;
      end else if (state == WAIT_REQ || state == READ) begin
        tcnt <= tcnt + 1'b1;
      end

      if (capture) begin
        if (!phase) begin
          low_byte <= data_i;
          phase    <= 1'b1;
        end else begin
          word_valid <= 1'b1;
          word_data  <= {data_i, low_byte};
          word_addr  <= count;
          if (count != CNT_MAX) count <= count + 1'b1;
          phase      <= 1'b0;
        end
      end

      // A pending odd low byte is simply dropped: only whole words count.
      if (state_nxt == DONE || state_nxt == TOUT)
        word_count <= count;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_host
//  Purpose  : Directed self-checking bench for bus_host. A transaction-level
//             model turns each directed scenario into a per-cycle table of
//             expected outputs, checked every cycle, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_host;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;
  localparam int N     = 1024;
  localparam int RDN   = 128;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_we, start, req_i, fin_i;
  logic [3:0]  cmd_waddr;
  logic [7:0]  cmd_wdata, data_i;
  logic [4:0]  cmd_len;
  logic        busy, done, timeout, word_valid, dir_o, req_o, req_oe, data_oe;
  logic [15:0] word_data;
  logic [16:0] word_addr, word_count;
  logic [7:0]  data_o;

  bus_host #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_we(cmd_we), .cmd_waddr(cmd_waddr),
    .cmd_wdata(cmd_wdata), .cmd_len(cmd_len), .start(start), .busy(busy),
    .done(done), .timeout(timeout), .word_valid(word_valid),
    .word_data(word_data), .word_addr(word_addr), .word_count(word_count),
    .dir_o(dir_o), .req_o(req_o), .req_oe(req_oe), .req_i(req_i),
    .data_o(data_o), .data_oe(data_oe), .data_i(data_i), .fin_i(fin_i)
  );

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  chk_en = 1'b0;

  // Expected per-cycle outputs.
  bit          e_dir [N];
  bit          e_req [N];
  bit          e_busy[N];
  bit          e_done[N];
  bit          e_tout[N];
  bit          e_wv  [N];
  logic [7:0]  e_data[N];
  logic [15:0] e_wd  [N];
  logic [16:0] e_wa  [N];
  logic [16:0] e_wc  [N];

  logic [7:0]  bmem[DEPTH];

  // Peripheral script, index 0 = first WAIT_REQ cycle.
  bit          rd_req[RDN];
  bit          rd_fin[RDN];
  bit          rd_st [RDN];
  logic [7:0]  rd_dat[RDN];

  // Observation logs for literal checks.
  logic [7:0]  wq[$];
  logic [32:0] wlog[$];
  int          done_c, tout_c, dirfall_c, firstreq_c;
  logic [16:0] wc_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_word(input int idx, input logic [16:0] addr, input logic [15:0] data);
    if (idx < wlog.size()) begin
      chk("word_log_addr", 32'(wlog[idx][32:16]), 32'(addr));
      chk("word_log_data", 32'(wlog[idx][15:0]), 32'(data));
    end else begin
      chk("word_log_present", 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  task automatic compare();
    int c = cyc;
    if (chk_en && c < N) begin
      chk("dir_o",      32'(dir_o),      32'(e_dir[c]));
      chk("req_oe",     32'(req_oe),     32'(e_dir[c]));
      chk("data_oe",    32'(data_oe),    32'(e_dir[c]));
      chk("req_o",      32'(req_o),      32'(e_req[c]));
      chk("data_o",     32'(data_o),     32'(e_data[c]));
      chk("busy",       32'(busy),       32'(e_busy[c]));
      chk("done",       32'(done),       32'(e_done[c]));
      chk("timeout",    32'(timeout),    32'(e_tout[c]));
      chk("word_valid", 32'(word_valid), 32'(e_wv[c]));
      if (e_wv[c]) begin
        chk("word_data", 32'(word_data), 32'(e_wd[c]));
        chk("word_addr", 32'(word_addr), 32'(e_wa[c]));
      end
      chk("word_count", 32'(word_count), 32'(e_wc[c]));
    end
    if (req_o === 1'b1) begin
      wq.push_back(data_o);
      if (firstreq_c < 0) firstreq_c = c;
    end
    if (word_valid === 1'b1) wlog.push_back({word_addr, word_data});
    if (done === 1'b1)    begin done_c = c; wc_end = word_count; end
    if (timeout === 1'b1) begin tout_c = c; wc_end = word_count; end
    if (dir_o === 1'b0 && dirfall_c < 0) dirfall_c = c;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Fill the expectation table for a transaction started in cycle s.
  task automatic model(input int s, input int len, output int w, output int e);
    int L, cnt, c;
    bit waiting, ph, is_to;
    logic [7:0] lo;
    L = (len > DEPTH) ? DEPTH : len;
    e_busy[s+1] = 1'b1;
    for (int k = 0; k < L; k++) begin
      e_busy[s+2+k] = 1'b1;
      e_req[s+2+k]  = 1'b1;
      e_data[s+2+k] = bmem[k];
    end
    e_busy[s+2+L] = 1'b1;
    w = s + 3 + L;
    waiting = 1'b1; ph = 1'b0; lo = 8'h00; cnt = 0; is_to = 1'b0; e = w + TMO;
    for (int i = 0; i < TMO; i++) begin
      c = w + i;
      e_dir[c]  = 1'b0;
      e_busy[c] = 1'b1;
      if (rd_fin[i]) begin e = c + 1; break; end
      if (i + 1 == TMO) begin e = c + 1; is_to = 1'b1; break; end
      if (rd_req[i]) begin
        if (waiting) waiting = 1'b0;
        else if (!ph) begin lo = rd_dat[i]; ph = 1'b1; end
        else begin
          e_wv[c+1] = 1'b1;
          e_wd[c+1] = {rd_dat[i], lo};
          e_wa[c+1] = cnt[16:0];
          cnt++;
          ph = 1'b0;
        end
      end
    end
    e_dir[e]  = 1'b0;
    e_busy[e] = 1'b1;
    if (is_to) e_tout[e] = 1'b1;
    else       e_done[e] = 1'b1;
    for (int k = e; k < N; k++) e_wc[k] = cnt[16:0];
  endtask

  // Reset sampled at the end of cycle r: everything idle from r+1 onward.
  task automatic model_reset(input int r);
    for (int k = r + 1; k < N; k++) begin
      e_dir[k] = 1'b1; e_req[k] = 1'b0; e_data[k] = 8'h00; e_busy[k] = 1'b0;
      e_done[k] = 1'b0; e_tout[k] = 1'b0; e_wv[k] = 1'b0; e_wc[k] = '0;
    end
  endtask

  task automatic clr_rd();
    for (int i = 0; i < RDN; i++) begin
      rd_req[i] = 1'b0; rd_fin[i] = 1'b0; rd_st[i] = 1'b0; rd_dat[i] = 8'h00;
    end
  endtask

  task automatic set_rd(input int i, input bit rq, input bit fn, input logic [7:0] d, input bit st);
    rd_req[i] = rq; rd_fin[i] = fn; rd_dat[i] = d; rd_st[i] = st;
  endtask

  task automatic write_cmd(input int a, input logic [7:0] d);
    cmd_we = 1'b1; cmd_waddr = 4'(a); cmd_wdata = d;
    bmem[a] = d;
    tick();
    cmd_we = 1'b0;
  endtask

  task automatic run_txn(input int len, input int rst_at, output int s, output int w);
    int e;
    wq.delete(); wlog.delete();
    done_c = -1; tout_c = -1; dirfall_c = -1; firstreq_c = -1; wc_end = '1;
    s = cyc;
    start = 1'b1; cmd_len = 5'(len);
    model(s, len, w, e);
    tick();
    start = 1'b0;
    while (cyc < w) tick();
    for (int i = 0; i < e - w; i++) begin
      req_i = rd_req[i]; fin_i = rd_fin[i]; data_i = rd_dat[i]; start = rd_st[i];
      if (i == rst_at) begin rst_n = 1'b0; model_reset(cyc); end
      tick();
      if (i == rst_at) begin rst_n = 1'b1; break; end
    end
    req_i = 1'b0; fin_i = 1'b0; data_i = 8'h00; start = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int s, w;
    for (int k = 0; k < N; k++) begin
      e_dir[k] = 1'b1; e_req[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
      e_tout[k] = 1'b0; e_wv[k] = 1'b0; e_data[k] = 8'h00; e_wd[k] = '0;
      e_wa[k] = '0; e_wc[k] = '0;
    end
    for (int k = 0; k < DEPTH; k++) bmem[k] = 8'h00;
    clr_rd();
    rst_n = 1'b0; cmd_we = 1'b0; cmd_waddr = 4'h0; cmd_wdata = 8'h00;
    cmd_len = 5'd0; start = 1'b0; req_i = 1'b0; fin_i = 1'b0; data_i = 8'h00;

    @(posedge clk); #1;
    tick();                       // first reset edge
    chk_en = 1'b1;
    chk("reset_word_data", 32'(word_data), 32'h0);
    chk("reset_word_addr", 32'(word_addr), 32'h0);
    tick();                       // reset state checked by table
    rst_n = 1'b1;

    // Send 3 bytes, receive two words.
    write_cmd(0, 8'h11); write_cmd(1, 8'h22); write_cmd(2, 8'h33);
    clr_rd();
    set_rd(0, 1, 0, 8'h00, 0);
    set_rd(1, 1, 0, 8'h34, 0); set_rd(2, 1, 0, 8'h12, 0);
    set_rd(3, 1, 0, 8'h78, 0); set_rd(4, 1, 0, 8'h56, 0);
    set_rd(5, 0, 1, 8'h00, 0);
    run_txn(3, -1, s, w);
    chk("t1_nbytes", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk("t1_byte0", 32'(wq[0]), 32'h11);
      chk("t1_byte1", 32'(wq[1]), 32'h22);
      chk("t1_byte2", 32'(wq[2]), 32'h33);
    end
    chk("t1_pre_len",  32'(firstreq_c - s), 32'd2);
    chk("t1_dir_fall", 32'(dirfall_c - s),  32'd6);
    chk("t1_nwords",   32'(wlog.size()),    32'd2);
    chk_word(0, 17'd0, 16'h1234);
    chk_word(1, 17'd1, 16'h5678);
    chk("t1_done_at",  32'(done_c - s), 32'd12);
    chk("t1_wcount",   32'(wc_end), 32'd2);

    // Gaps between bytes, ignored start, trailing odd byte with fin+req.
    clr_rd();
    set_rd(0, 1, 0, 8'h00, 0);
    set_rd(1, 1, 0, 8'hCD, 0); set_rd(2, 0, 0, 8'hFF, 0);
    set_rd(3, 0, 0, 8'hEE, 1); set_rd(4, 1, 0, 8'hAB, 0);
    set_rd(5, 0, 0, 8'h00, 0); set_rd(6, 1, 0, 8'h01, 0);
    set_rd(7, 1, 0, 8'h02, 0); set_rd(8, 1, 0, 8'h99, 0);
    set_rd(9, 1, 1, 8'h77, 0);
    run_txn(1, -1, s, w);
    chk("t2_nwords", 32'(wlog.size()), 32'd2);
    chk_word(0, 17'd0, 16'hABCD);
    chk_word(1, 17'd1, 16'h0201);
    chk("t2_wcount", 32'(wc_end), 32'd2);

    // Zero-length command: PRE, POST, then WAIT_REQ.
    clr_rd();
    set_rd(0, 0, 1, 8'h00, 0);
    run_txn(0, -1, s, w);
    chk("t4_no_req",   32'(wq.size()),     32'd0);
    chk("t4_dir_fall", 32'(dirfall_c - s), 32'd3);
    chk("t4_done_at",  32'(done_c - s),    32'd4);
    chk("t4_wcount",   32'(wc_end),        32'd0);

    // Peripheral never answers: timeout after TMO cycles in WAIT_REQ.
    clr_rd();
    run_txn(2, -1, s, w);
    chk("t3_tout_at", 32'(tout_c - w), 32'd100);
    chk("t3_no_done", 32'(done_c),     32'hFFFFFFFF);
    chk("t3_wcount",  32'(wc_end),     32'd0);

    // Oversized cmd_len is clamped to the buffer depth.
    for (int k = 0; k < DEPTH; k++) write_cmd(k, 8'(8'hA0 + k));
    clr_rd();
    set_rd(0, 1, 0, 8'h00, 0);
    set_rd(1, 1, 0, 8'h01, 0); set_rd(2, 1, 0, 8'h02, 0);
    set_rd(3, 0, 1, 8'h00, 0);
    run_txn(20, -1, s, w);
    chk("t5_nbytes", 32'(wq.size()), 32'd16);
    if (wq.size() == 16) chk("t5_last_byte", 32'(wq[15]), 32'hAF);
    chk("t5_wcount", 32'(wc_end), 32'd1);

    // Reset mid-READ: abort without done, then a normal transaction.
    clr_rd();
    set_rd(0, 1, 0, 8'h00, 0);
    set_rd(1, 1, 0, 8'h34, 0); set_rd(2, 1, 0, 8'h12, 0);
    set_rd(3, 1, 0, 8'h78, 0); set_rd(4, 0, 1, 8'h00, 0);
    run_txn(1, 3, s, w);
    chk("t6_no_done", 32'(done_c), 32'hFFFFFFFF);
    chk("t6_nwords",  32'(wlog.size()), 32'd1);
    chk_word(0, 17'd0, 16'h1234);

    clr_rd();
    set_rd(0, 1, 0, 8'h00, 0);
    set_rd(1, 1, 0, 8'h55, 0); set_rd(2, 1, 0, 8'hAA, 0);
    set_rd(3, 0, 1, 8'h00, 0);
    run_txn(2, -1, s, w);
    chk("t7_byte0", 32'(wq.size() > 0 ? wq[0] : 8'h00), 32'hA0);
    chk_word(0, 17'd0, 16'hAA55);
    chk("t7_wcount", 32'(wc_end), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_host.md
BUS_HOST -- requirements
Module: bus_host

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 16, giving the command buffer size in bytes (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 2**20, giving the maximum number of cycles spent waiting for peripheral req_i or fin_i.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port cmd_we, input, 1 bit: writes cmd_wdata into command buffer entry cmd_waddr.
REQ-006 SHALL have port cmd_waddr, input, $clog2(CMD_DEPTH) bits: the command buffer entry index.
REQ-007 SHALL have port cmd_wdata, input, 8 bits: the command byte.
REQ-008 SHALL have port cmd_len, input, $clog2(CMD_DEPTH)+1 bits: the number of bytes to send, sampled on start.
REQ-009 SHALL have port start, input, 1 bit: a one-cycle transaction request.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse at normal completion.
REQ-012 SHALL have port timeout, output, 1 bit: a one-cycle pulse at timeout completion.
REQ-013 SHALL have port word_valid, output, 1 bit: marks each received 16-bit word.
REQ-014 SHALL have port word_data, output, 16 bits: the received word, {high byte, low byte}.
REQ-015 SHALL have port word_addr, output, 17 bits: the index of the word, starting at 0.
REQ-016 SHALL have port word_count, output, 17 bits: the number of words received in the last transaction.
REQ-017 SHALL have port dir_o, output, 1 bit: the bus direction; 1 means host drives the bus and holds the peripheral in reset.
REQ-018 SHALL have ports req_o, output, 1 bit, and req_oe, output, 1 bit: the host req strobe and its drive enable.
REQ-019 SHALL have port req_i, input, 1 bit: the peripheral data-ready indication.
REQ-020 SHALL have ports data_o, output, 8 bits, and data_oe, output, 1 bit: the host data byte and its drive enable.
REQ-021 SHALL have port data_i, input, 8 bits: the peripheral data byte.
REQ-022 SHALL have port fin_i, input, 1 bit: the peripheral frame-complete indication.

Function
REQ-023 SHALL use the FSM states IDLE, PRE, WRITE, POST, WAIT_REQ, READ, DONE, TOUT.
REQ-024 SHALL, in IDLE, hold dir_o=1, req_o=0 and data_o=0, keeping the peripheral in reset.
REQ-025 SHALL accept cmd_we in any state; a write during WRITE to the entry being sent SHALL be undefined and need not be checked.
REQ-026 SHALL, on start in IDLE, latch cmd_len and go to PRE; start SHALL be ignored while busy=1.
REQ-027 SHALL, in PRE, hold dir_o=1 and req_o=0 for exactly 1 cycle, so the peripheral write address clears; next state is WRITE if cmd_len!=0, else POST.
REQ-028 SHALL, in WRITE, hold req_o=1 continuously for exactly cmd_len consecutive cycles, with data_o=buf[k] on the k-th cycle (k=0..cmd_len-1), with no gaps.
REQ-029 SHALL treat cmd_len>CMD_DEPTH as CMD_DEPTH.
REQ-030 SHALL, in POST, drive dir_o=1 and req_o=0 for 1 cycle, then go to WAIT_REQ.
REQ-031 SHALL set req_oe=data_oe=dir_o in every cycle; in WAIT_REQ, READ, DONE and TOUT, dir_o=0, so both drivers are released in the same cycle dir_o falls.
REQ-032 SHALL, in WAIT_REQ, clear the byte phase and word counter, and go to READ on the first cycle with req_i=1.
REQ-033 SHALL, in READ, capture data_i on every cycle with req_i=1 and fin_i=0, alternating low byte then high byte starting with low.
REQ-034 SHALL, on each high-byte capture, assert word_valid for 1 cycle on the next cycle with word_data={high,low} and word_addr=current count, then increment the count.
REQ-035 SHALL ignore cycles in READ with req_i=0, so the byte phase holds.
REQ-036 SHALL, on fin_i=1 in WAIT_REQ or READ, go to DONE; any captured odd low byte SHALL be discarded; word_count SHALL be loaded with the count.
REQ-037 SHALL, in DONE, pulse done for 1 cycle, then return to IDLE with dir_o=1.
REQ-038 SHALL count cycles since entering WAIT_REQ; when the counter reaches TIMEOUT before fin_i, the block SHALL go to TOUT, pulse timeout for 1 cycle, load word_count, and return to IDLE.
REQ-039 SHALL saturate the word counter at 2**17-1 with no wrap.
REQ-040 SHALL give fin_i priority over a simultaneous req_i capture and over a simultaneous timeout.

Reset
REQ-041 SHALL, while rst_n=0 at a clock edge, force IDLE, dir_o=1, req_o=0, req_oe=1, data_o=0, data_oe=1, busy=0, done=0, timeout=0, word_valid=0, word_data=0, word_addr=0, word_count=0, and clear all counters.
REQ-042 SHALL leave command buffer contents unaffected by reset.
REQ-043 SHALL, when reset is applied mid-transaction, abort on the next edge with no done or timeout pulse; dir_o=1 re-holds the peripheral in reset.

Verification
REQ-044 SHALL verify: load bytes 0x11,0x22,0x33 with cmd_len=3, then start -> PRE for 1 cycle, then req_o=1 for exactly 3 cycles with data_o 0x11,0x22,0x33, then POST, then dir_o=0.
REQ-045 SHALL verify: peripheral model sends req_i=1 with bytes 0x34,0x12,0x78,0x56, then fin_i -> word_valid twice with 0x1234@0 and 0x5678@1, then done with word_count=2.
REQ-046 SHALL verify: req_i gaps between low and high bytes -> pairing preserved and the words are unchanged.
REQ-047 SHALL verify: req_i never rises with TIMEOUT=100 -> timeout pulse 100 cycles after WAIT_REQ entry, word_count=0, return to IDLE with dir_o=1.
REQ-048 SHALL verify: cmd_len=0 -> no req_o pulse, and PRE then POST then WAIT_REQ.
REQ-049 SHALL verify: rst_n=0 for 1 cycle mid-READ -> next cycle IDLE, dir_o=1, no done, and a following start works normally.
